// File: rtl/way_read_mux.sv
// N-way tag compare and read-data select for the set-associative cache.
// Results pass through a 2-entry registered buffer; hit/miss statistics saturate.
module way_read_mux #(
    parameter int WAYS   = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 20,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TAG_W-1:0]          req_tag,
    input  logic [WAYS*TAG_W-1:0]     way_tag,
    input  logic [WAYS-1:0]           way_valid,
    input  logic [WAYS*DATA_W-1:0]    way_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_hit,
    output logic [$clog2(WAYS)-1:0]   out_way,
    output logic                      out_multi,
    input  logic                      stat_clr,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt
);
    localparam int WAY_W = $clog2(WAYS);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              hit;
        logic [WAY_W-1:0]  way;
        logic              multi;
    } entry_t;

    logic [WAYS-1:0] match;
    entry_t          lookup;
    entry_t          slot_q [2];
    logic [1:0]      count;
    logic            push;
    logic            pop;

    always_comb begin
        match = '0;
        for (int i = 0; i < WAYS; i++) begin
            match[i] = way_valid[i] && (way_tag[i*TAG_W +: TAG_W] == req_tag);
        end
    end

    // Ascending scan: the first match wins the select, any later match flags a multi-hit.
    always_comb begin
        lookup = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (match[i]) begin
                if (lookup.hit) begin
                    lookup.multi = 1'b1;
                end else begin
                    lookup.hit  = 1'b1;
                    lookup.way  = WAY_W'(i);
                    lookup.data = way_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // slot_q[0] is always the head; vacated slots are zeroed so an empty buffer shows zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot_q[0] <= lookup;
                    else               slot_q[1] <= lookup;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot_q[0] <= slot_q[1];
                    slot_q[1] <= '0;
                    count     <= count - 2'd1;
                end
                // Simultaneous push and pop can only happen with exactly one entry held.
                2'b11: slot_q[0] <= lookup;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (stat_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (push) begin
            if (lookup.hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    assign out_data  = slot_q[0].data;
    assign out_hit   = slot_q[0].hit;
    assign out_way   = slot_q[0].way;
    assign out_multi = slot_q[0].multi;

endmodule

// File: tb/tb_way_read_mux.sv
// Self-checking bench for way_read_mux: directed vector table, backpressure,
// saturation and async-reset sequences, then random traffic against a queue model.
module tb_way_read_mux;
    localparam int WAYS   = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 20;
    localparam int CNT_W  = 4;
    localparam int WAY_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [TAG_W-1:0]       req_tag;
    logic [WAYS*TAG_W-1:0]  way_tag;
    logic [WAYS-1:0]        way_valid;
    logic [WAYS*DATA_W-1:0] way_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic                   out_hit;
    logic [WAY_W-1:0]       out_way;
    logic                   out_multi;
    logic                   stat_clr;
    logic [CNT_W-1:0]       hit_cnt;
    logic [CNT_W-1:0]       miss_cnt;

    way_read_mux #(.WAYS(WAYS), .DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .req_tag(req_tag), .way_tag(way_tag), .way_valid(way_valid), .way_data(way_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_hit(out_hit), .out_way(out_way), .out_multi(out_multi),
        .stat_clr(stat_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              hit;
        logic [WAY_W-1:0]  way;
        logic              multi;
    } res_t;

    typedef struct {
        logic [TAG_W-1:0]       tag;
        logic [WAYS*TAG_W-1:0]  wt;
        logic [WAYS-1:0]        wv;
        logic [WAYS*DATA_W-1:0] wd;
        logic [DATA_W-1:0]      edata;
        logic                   ehit;
        logic [WAY_W-1:0]       eway;
        logic                   emulti;
    } vec_t;

    res_t model_q[$];
    int   model_hits;
    int   model_misses;
    int   vectors;
    int   miscompares;
    int   max_cnt;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference lookup: collect all hitting ways in order; first one is selected.
    function automatic res_t refLookup(input logic [TAG_W-1:0] tag, input logic [WAYS*TAG_W-1:0] wt,
                                       input logic [WAYS-1:0] wv, input logic [WAYS*DATA_W-1:0] wd);
        int   hits[$];
        res_t r;
        r = '0;
        for (int i = 0; i < WAYS; i++)
            if (wv[i] && wt[i*TAG_W +: TAG_W] == tag) hits.push_back(i);
        if (hits.size() > 0) begin
            r.hit   = 1'b1;
            r.way   = WAY_W'(hits[0]);
            r.data  = wd[hits[0]*DATA_W +: DATA_W];
            r.multi = (hits.size() > 1);
        end
        return r;
    endfunction

    task automatic checkOutput();
        res_t head;
        head = (model_q.size() != 0) ? model_q[0] : '0;
        cmp("in_ready",  64'(in_ready),  64'(model_q.size() != 2));
        cmp("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
        cmp("out_data",  64'(out_data),  64'(head.data));
        cmp("out_hit",   64'(out_hit),   64'(head.hit));
        cmp("out_way",   64'(out_way),   64'(head.way));
        cmp("out_multi", 64'(out_multi), 64'(head.multi));
        cmp("hit_cnt",   64'(hit_cnt),   64'(model_hits));
        cmp("miss_cnt",  64'(miss_cnt),  64'(model_misses));
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance the model at the rising edge.
    task automatic applyStimulus(input logic v, input logic [TAG_W-1:0] tag,
                                 input logic [WAYS*TAG_W-1:0] wt, input logic [WAYS-1:0] wv,
                                 input logic [WAYS*DATA_W-1:0] wd, input logic ordy, input logic clr);
        logic do_push;
        logic do_pop;
        res_t r;
        in_valid  = v;
        req_tag   = tag;
        way_tag   = wt;
        way_valid = wv;
        way_data  = wd;
        out_ready = ordy;
        stat_clr  = clr;
        @(negedge clk);
        checkOutput();
        do_push = v && (model_q.size() < 2);
        do_pop  = ordy && (model_q.size() != 0);
        r = refLookup(tag, wt, wv, wd);
        @(posedge clk);
        if (clr) begin
            model_hits   = 0;
            model_misses = 0;
        end else if (do_push) begin
            if (r.hit) model_hits   = (model_hits   < max_cnt) ? model_hits + 1   : max_cnt;
            else       model_misses = (model_misses < max_cnt) ? model_misses + 1 : max_cnt;
        end
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(r);
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, '0, '0, '0, '0, ordy, 1'b0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [WAYS*TAG_W-1:0]  wt;
        logic [WAYS*DATA_W-1:0] wd;
        vectors = 0; miscompares = 0;
        model_hits = 0; model_misses = 0;
        max_cnt = (1 << CNT_W) - 1;
        rst_n = 1'b0; in_valid = 0; req_tag = '0; way_tag = '0; way_valid = '0;
        way_data = '0; out_ready = 0; stat_clr = 0;

        vecs[0] = '{20'h12345, {20'h11111, 20'h12345, 20'h22222, 20'h33333}, 4'hF,
                    {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h0BADF00D},
                    32'hDEADBEEF, 1'b1, 2'd2, 1'b0};
        vecs[1] = '{20'h12345, {20'h11111, 20'h22222, 20'h12345, 20'h33333}, 4'b1101,
                    {32'h1, 32'h2, 32'h3, 32'h4}, 32'h0, 1'b0, 2'd0, 1'b0};
        vecs[2] = '{20'h12345, {20'h12345, 20'h00000, 20'h12345, 20'h00000}, 4'hF,
                    {32'hAAAA0003, 32'hAAAA0002, 32'hCAFEF00D, 32'hAAAA0000},
                    32'hCAFEF00D, 1'b1, 2'd1, 1'b1};
        vecs[3] = '{20'h55555, {4{20'h55555}}, 4'hF,
                    {32'hD3, 32'hD2, 32'hD1, 32'h600DD00D}, 32'h600DD00D, 1'b1, 2'd0, 1'b1};
        vecs[4] = '{20'hABCDE, {20'hABCDE, 20'h0, 20'h0, 20'h0}, 4'hF,
                    {32'h13572468, 32'h2, 32'h3, 32'h4}, 32'h13572468, 1'b1, 2'd3, 1'b0};
        vecs[5] = '{20'h77777, {4{20'h77777}}, 4'h0,
                    {4{32'hFFFFFFFF}}, 32'h0, 1'b0, 2'd0, 1'b0};

        // Reset state
        #12;
        checkOutput();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vector table: accept with out_ready high, result visible one edge later
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, vecs[k].tag, vecs[k].wt, vecs[k].wv, vecs[k].wd, 1'b1, 1'b0);
            cmp("vec_valid", 64'(out_valid), 64'(1));
            cmp("vec_data",  64'(out_data),  64'(vecs[k].edata));
            cmp("vec_hit",   64'(out_hit),   64'(vecs[k].ehit));
            cmp("vec_way",   64'(out_way),   64'(vecs[k].eway));
            cmp("vec_multi", 64'(out_multi), 64'(vecs[k].emulti));
        end
        idle(1'b1);

        // Backpressure: A and B accepted, C held off until a slot frees
        wt = {20'h00003, 20'h00002, 20'h00001, 20'h00000};
        wd = {32'hC0000003, 32'hB0000002, 32'hA0000001, 32'h90000000};
        applyStimulus(1'b1, 20'h00001, wt, 4'hF, wd, 1'b0, 1'b0);
        applyStimulus(1'b1, 20'h00002, wt, 4'hF, wd, 1'b0, 1'b0);
        cmp("bp_full_ready", 64'(in_ready), 64'(0));
        applyStimulus(1'b1, 20'h00003, wt, 4'hF, wd, 1'b0, 1'b0);
        applyStimulus(1'b1, 20'h00003, wt, 4'hF, wd, 1'b0, 1'b0);
        cmp("bp_head_a", 64'(out_data), 64'(32'hA0000001));
        applyStimulus(1'b1, 20'h00003, wt, 4'hF, wd, 1'b1, 1'b0);
        cmp("bp_ready_back", 64'(in_ready), 64'(1));
        cmp("bp_head_b", 64'(out_data), 64'(32'hB0000002));
        applyStimulus(1'b1, 20'h00003, wt, 4'hF, wd, 1'b1, 1'b0);
        cmp("bp_head_c", 64'(out_data), 64'(32'hC0000003));
        idle(1'b1);
        idle(1'b1);

        // Saturation, then clear wins over a same-cycle hit
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 17; k++)
            applyStimulus(1'b1, 20'h00002, wt, 4'hF, wd, 1'b1, 1'b0);
        cmp("sat_hit_cnt", 64'(hit_cnt), 64'(15));
        applyStimulus(1'b1, 20'h00002, wt, 4'hF, wd, 1'b1, 1'b1);
        cmp("clr_hit_cnt", 64'(hit_cnt), 64'(0));
        idle(1'b1);

        // Async reset with a full buffer, observed before the next edge
        applyStimulus(1'b1, 20'h00001, wt, 4'hF, wd, 1'b0, 1'b0);
        applyStimulus(1'b1, 20'h00009, wt, 4'hF, wd, 1'b0, 1'b0);
        cmp("pre_rst_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        model_hits = 0;
        model_misses = 0;
        cmp("rst_out_valid", 64'(out_valid), 64'(0));
        cmp("rst_in_ready",  64'(in_ready),  64'(1));
        cmp("rst_out_data",  64'(out_data),  64'(0));
        cmp("rst_out_hit",   64'(out_hit),   64'(0));
        cmp("rst_out_way",   64'(out_way),   64'(0));
        cmp("rst_out_multi", 64'(out_multi), 64'(0));
        cmp("rst_hit_cnt",   64'(hit_cnt),   64'(0));
        cmp("rst_miss_cnt",  64'(miss_cnt),  64'(0));
        #1;
        rst_n = 1'b1;
        idle(1'b0);

        // Random traffic drawn from a small tag pool so hits, misses and multi-hits all occur
        for (int k = 0; k < 400; k++) begin
            logic [TAG_W-1:0]       t;
            logic [WAYS*TAG_W-1:0]  rwt;
            logic [WAYS*DATA_W-1:0] rwd;
            t = TAG_W'($urandom_range(0, 3));
            for (int w = 0; w < WAYS; w++) begin
                rwt[w*TAG_W +: TAG_W]   = TAG_W'($urandom_range(0, 5));
                rwd[w*DATA_W +: DATA_W] = $urandom;
            end
            applyStimulus(1'($urandom_range(0, 1)), t, rwt, WAYS'($urandom), rwd,
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
